// File: rtl/axi_lite_read_data_slave.sv
// AXI4-Lite read path: AR queue with decode/protection classification,
// synchronous word-memory fetch and an R channel held until RREADY.
module axi_lite_read_data_slave #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                MEM_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                QDEPTH    = 2,
  parameter bit                PRIV_ONLY = 1'b0,
  localparam int               IW        = $clog2(MEM_WORDS)
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [2:0]        ARPROT,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              mem_rd_en,
  output logic [IW-1:0]     mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_RESP
  } state_e;

  state_e            state_q;
  logic              arready_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;

  logic [IW-1:0]     q_idx_q  [QDEPTH];
  logic [1:0]        q_resp_q [QDEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;

  logic [ADDR_W-1:0] ar_off;
  logic              ar_in_range;
  logic [1:0]        ar_resp;
  logic [IW-1:0]     ar_idx;
  logic              push;
  logic              pop;
  logic [IW-1:0]     head_idx;
  logic [1:0]        head_resp;
  logic              unused_ok;

  assign ar_off      = ARADDR - BASE_ADDR;
  assign ar_in_range = (ARADDR >= BASE_ADDR)
                    && ((ar_off >> (IW + 2)) == '0);
  assign ar_idx      = ar_off[IW+1:2];
  assign unused_ok   = ^{ar_off[1:0], ARPROT[2:1]};

  // Decode error outranks alignment, alignment outranks privilege
  always_comb begin
    ar_resp = RESP_OKAY;
    priority case (1'b1)
      !ar_in_range:             ar_resp = RESP_DECERR;
      (ARADDR[1:0] != 2'b00):   ar_resp = RESP_SLVERR;
      (PRIV_ONLY && !ARPROT[0]): ar_resp = RESP_SLVERR;
      default:                  ar_resp = RESP_OKAY;
    endcase
  end

  assign push      = ARVALID && arready_q;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign head_idx  = q_idx_q[rd_ptr_q];
  assign head_resp = q_resp_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (push) begin
      q_idx_q[wr_ptr_q]  <= ar_idx;
      q_resp_q[wr_ptr_q] <= ar_resp;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q   <= S_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      arready_q <= (count_d < QFULL);
      count_q   <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            if (head_resp == RESP_OKAY) begin
              state_q <= S_FETCH;
            end else begin
              rdata_q  <= '0;
              rresp_q  <= head_resp;
              rvalid_q <= 1'b1;
              state_q  <= S_RESP;
            end
          end
        end
        S_FETCH: begin
          rdata_q  <= mem_rdata;
          rresp_q  <= RESP_OKAY;
          rvalid_q <= 1'b1;
          state_q  <= S_RESP;
        end
        S_RESP: begin
          if (RREADY) begin
            rvalid_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read strobe follows the pop so data lands while in FETCH
  assign mem_rd_en = pop && (head_resp == RESP_OKAY);
  assign mem_addr  = head_idx;

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_read_data_slave.sv
// Directed bench for axi_lite_read_data_slave: vector table plus
// backpressure, streaming, privilege and mid-transaction reset sequences.
module tb_axi_lite_read_data_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] ARADDR = '0;
  logic [2:0]  ARPROT = '0;
  logic        RVALID;
  logic        RREADY = 1'b1;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata = '0;

  logic        p_arvalid = 1'b0;
  logic        p_arready;
  logic        p_rvalid;
  logic [31:0] p_rdata;
  logic [1:0]  p_rresp;
  logic        p_mem_rd_en;
  logic [7:0]  p_mem_addr;
  logic [31:0] p_mem_rdata = '0;

  logic [31:0] mem [256];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 ACLK = ~ACLK;

  axi_lite_read_data_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY),
    .RDATA(RDATA), .RRESP(RRESP),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata)
  );

  axi_lite_read_data_slave #(.PRIV_ONLY(1'b1)) dut_priv (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARVALID(p_arvalid), .ARREADY(p_arready),
    .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(p_rvalid), .RREADY(RREADY),
    .RDATA(p_rdata), .RRESP(p_rresp),
    .mem_rd_en(p_mem_rd_en), .mem_addr(p_mem_addr),
    .mem_rdata(p_mem_rdata)
  );

  always @(posedge ACLK) begin
    if (mem_rd_en)   mem_rdata   <= mem[mem_addr];
    if (p_mem_rd_en) p_mem_rdata <= mem[p_mem_addr];
  end

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  prot;
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;
    bit          memrd;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_ar(input logic [31:0] a, input logic [2:0] p);
    int n = 0;
    while (!ARREADY && n < 200) begin
      @(posedge ACLK); #1;
      n++;
    end
    chk("ar_ready", {31'b0, ARREADY}, 32'd1);
    ARVALID = 1'b1;
    ARADDR  = a;
    ARPROT  = p;
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
  endtask

  task automatic wait_rvalid(input string nm);
    int n = 0;
    while (!RVALID && n < 20) begin
      @(posedge ACLK); #1;
      n++;
    end
    chk(nm, {31'b0, RVALID}, 32'd1);
  endtask

  task automatic do_vec(input vec_t v, input int i);
    bit rd = 1'b0;
    int lat = -1;
    logic [1:0]  resp = 2'bxx;
    logic [31:0] data = 'x;
    RREADY = 1'b1;
    push_ar(v.addr, v.prot);
    for (int k = 1; k <= 20; k++) begin
      @(negedge ACLK);
      if (mem_rd_en) rd = 1'b1;
      if (RVALID) begin
        lat  = k - 1;
        resp = RRESP;
        data = RDATA;
        break;
      end
    end
    chk($sformatf("v%0d_resp", i), {30'b0, resp}, {30'b0, v.resp});
    chk($sformatf("v%0d_data", i), data, v.data);
    chk($sformatf("v%0d_lat", i), lat, v.lat);
    chk($sformatf("v%0d_memrd", i), {31'b0, rd}, {31'b0, v.memrd});
    @(posedge ACLK); #1;
    chk($sformatf("v%0d_rv_drop", i), {31'b0, RVALID}, 32'd0);
  endtask

  task automatic p_read(input logic [2:0] p, input logic [1:0] er,
                        input logic [31:0] ed, input bit erd);
    bit rd  = 1'b0;
    bit got = 1'b0;
    RREADY = 1'b1;
    chk("priv_arready", {31'b0, p_arready}, 32'd1);
    p_arvalid = 1'b1;
    ARADDR    = 32'h10;
    ARPROT    = p;
    @(posedge ACLK); #1;
    p_arvalid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge ACLK);
      if (p_mem_rd_en) rd = 1'b1;
      if (p_rvalid) begin
        got = 1'b1;
        chk($sformatf("priv%0d_resp", p), {30'b0, p_rresp}, {30'b0, er});
        chk($sformatf("priv%0d_data", p), p_rdata, ed);
        break;
      end
    end
    chk($sformatf("priv%0d_rvalid", p), {31'b0, got}, 32'd1);
    chk($sformatf("priv%0d_memrd", p), {31'b0, rd}, {31'b0, erd});
    @(posedge ACLK); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s_addr [10];
    logic [1:0]  s_resp [10];
    logic [31:0] s_data [10];
    logic [31:0] first;
    int  got;
    bit  stable;
    bit  stale;

    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[3] = 32'hDEADBEEF;

    vecs[0] = '{32'h0000_000C, 3'b000, 2'b00, 32'hDEADBEEF, 2, 1'b1};
    vecs[1] = '{32'h0000_0400, 3'b000, 2'b11, 32'h0,        1, 1'b0};
    vecs[2] = '{32'h0000_0006, 3'b000, 2'b10, 32'h0,        1, 1'b0};
    vecs[3] = '{32'h0000_03FC, 3'b000, 2'b00, 32'hC0DE_00FF, 2, 1'b1};
    vecs[4] = '{32'h0000_0000, 3'b000, 2'b00, 32'hC0DE_0000, 2, 1'b1};
    vecs[5] = '{32'hFFFF_FFFC, 3'b001, 2'b11, 32'h0,        1, 1'b0};
    vecs[6] = '{32'h0000_03FD, 3'b000, 2'b10, 32'h0,        1, 1'b0};
    vecs[7] = '{32'h0000_0401, 3'b000, 2'b11, 32'h0,        1, 1'b0};

    // reset values
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_arready", {31'b0, ARREADY}, 32'd0);
    chk("rst_rvalid", {31'b0, RVALID}, 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_rresp", {30'b0, RRESP}, 32'd0);
    chk("rst_memrd", {31'b0, mem_rd_en}, 32'd0);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    chk("rel_arready", {31'b0, ARREADY}, 32'd1);

    for (int i = 0; i < 8; i++) do_vec(vecs[i], i);

    // privileged-only instance
    p_read(3'b000, 2'b10, 32'h0, 1'b0);
    p_read(3'b001, 2'b00, 32'hC0DE_0004, 1'b1);

    // backpressure: one beat held, two queued, third AR refused
    RREADY = 1'b0;
    push_ar(32'h10, 3'b000);
    wait_rvalid("bp_first_rvalid");
    first = RDATA;
    push_ar(32'h14, 3'b000);
    push_ar(32'h18, 3'b000);
    chk("bp_arready_full", {31'b0, ARREADY}, 32'd0);
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge ACLK); #1;
      if (!RVALID || RDATA !== first || RRESP !== 2'b00) stable = 1'b0;
    end
    chk("bp_stable", {31'b0, stable}, 32'd1);
    chk("bp_first_data", first, 32'hC0DE_0004);
    chk("bp_arready_hold", {31'b0, ARREADY}, 32'd0);
    RREADY = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 3; c++) begin
      @(negedge ACLK);
      if (RVALID) begin
        chk($sformatf("bp_beat%0d", got), RDATA, 32'hC0DE_0004 + got);
        got++;
      end
    end
    chk("bp_beats", got, 32'd3);
    @(posedge ACLK); #1;

    // streaming with random RREADY
    for (int i = 0; i < 10; i++) begin
      s_addr[i] = 32'h40 + 4 * i;
      s_resp[i] = 2'b00;
      s_data[i] = 32'hC0DE_0010 + i;
    end
    s_addr[4] = 32'h800; s_resp[4] = 2'b11; s_data[4] = 32'h0;
    s_addr[7] = 32'h5E;  s_resp[7] = 2'b10; s_data[7] = 32'h0;
    got = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) push_ar(s_addr[i], 3'b000);
      end
      begin
        for (int c = 0; c < 600 && got < 10; c++) begin
          @(posedge ACLK); #1;
          RREADY = 1'($urandom_range(0, 1));
          @(negedge ACLK);
          if (RVALID && RREADY) begin
            chk($sformatf("st%0d_data", got), RDATA, s_data[got]);
            chk($sformatf("st%0d_resp", got), {30'b0, RRESP},
                {30'b0, s_resp[got]});
            got++;
          end
        end
      end
    join
    chk("st_beats", got, 32'd10);
    @(posedge ACLK); #1;
    RREADY = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    chk("st_idle", {31'b0, RVALID}, 32'd0);

    // reset while a beat is held and one AR is queued
    RREADY = 1'b0;
    push_ar(32'h20, 3'b000);
    wait_rvalid("mr_rvalid");
    push_ar(32'h24, 3'b000);
    ARESETn = 1'b0;
    @(posedge ACLK); #1;
    chk("mr_rvalid0", {31'b0, RVALID}, 32'd0);
    chk("mr_arready0", {31'b0, ARREADY}, 32'd0);
    chk("mr_rdata0", RDATA, 32'd0);
    chk("mr_rresp0", {30'b0, RRESP}, 32'd0);
    chk("mr_memrd0", {31'b0, mem_rd_en}, 32'd0);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    RREADY  = 1'b1;
    @(posedge ACLK); #1;
    chk("mr_arready1", {31'b0, ARREADY}, 32'd1);
    stale = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge ACLK);
      if (RVALID || mem_rd_en) stale = 1'b1;
    end
    chk("mr_no_stale", {31'b0, stale}, 32'd0);
    @(posedge ACLK); #1;
    do_vec(vecs[0], 8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
